// File: rtl/acc_cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcodes, FSM states,
// ALU operation codes and the opcode-to-ALU decode helper.
package acc_cpu_pkg;

    // Instruction opcodes (upper nibble of each instruction word).
    // Values C, D and E are unassigned and execute as NOP.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_LDI = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_XOR = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_JC  = 4'hB,
        OP_HLT = 4'hF
    } opcode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Operations carried out by the combinational ALU.
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    // Select the ALU operation for an opcode; anything that does not use the
    // ALU result simply passes the memory operand through.
    function automatic alu_op_e alu_op_of(input opcode_e op);
        alu_op_e r;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_OR:   r = ALU_OR;
            OP_XOR:  r = ALU_XOR;
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU. ADD reports carry-out, SUB
// reports borrow (a < b unsigned); other operations report carry = 0.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit on both operands exposes carry-out / borrow as the MSB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Result and carry selection by operation.
    always_comb begin
        result = b;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised two-cycle accumulator CPU (FETCH -> EXEC) with Z/C flags,
// logic operations and conditional branches. imem/dmem are plain arrays that
// are loaded from outside the core; the core itself only writes dmem (STA).
// Optional build macro ACC_CPU_STEP_EN adds step_en/step single-step inputs.
//
// Timing: the EXEC cycle of every instruction has retire=1; pc already holds
// fetch address + 1 during EXEC, and acc/flags/dmem/branch target update on
// the clock edge that ends EXEC.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OPND_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ACC_CPU_STEP_EN
    input  logic              step_en,
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              halt,
    output logic              zf,
    output logic              cf,
    output logic              retire
);

    localparam int INSN_W = 4 + OPND_W;

    // Program and data memories; contents are preserved across reset.
    logic [INSN_W-1:0] imem [2**ADDR_W];
    logic [DATA_W-1:0] dmem [2**OPND_W];

    state_e            state;
    logic [INSN_W-1:0] ir;

    opcode_e           op;
    logic [OPND_W-1:0] opnd;
    logic [DATA_W-1:0] mval;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] target;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              go;

    assign op     = opcode_e'(ir[INSN_W-1 -: 4]);
    assign opnd   = ir[OPND_W-1:0];
    assign mval   = dmem[opnd];
    assign imm    = DATA_W'(opnd);
    assign target = ADDR_W'(opnd);
    assign alu_op = alu_op_of(op);

`ifdef ACC_CPU_STEP_EN
    // In step mode a fetch only happens in a cycle where step is high.
    assign go = !step_en || step;
`else
    assign go = 1'b1;
`endif

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (mval),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Control FSM with the architectural registers (pc, acc, flags, halt, retire).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            ir     <= '0;
            pc     <= '0;
            acc    <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            halt   <= 1'b0;
            retire <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (go) begin
                        ir     <= imem[pc];
                        pc     <= pc + ADDR_W'(1);
                        retire <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            acc <= alu_res;
                            zf  <= (alu_res == '0);
                            if (op == OP_ADD || op == OP_SUB) begin
                                cf <= alu_carry;
                            end
                        end
                        OP_LDI: begin
                            acc <= imm;
                            zf  <= (imm == '0);
                        end
                        OP_JMP: pc <= target;
                        OP_JZ:  if (zf) pc <= target;
                        OP_JC:  if (cf) pc <= target;
                        OP_HLT: begin
                            halt  <= 1'b1;
                            state <= HALTED;
                        end
                        default: ;
                    endcase
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    // STA write lands on the edge that ends EXEC, so the next instruction sees it.
    always_ff @(posedge clk) begin
        if (state == EXEC && op == OP_STA) begin
            dmem[opnd] <= acc;
        end
    end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: an ISA-level reference interpreter predicts, per
// retired instruction, {pc during EXEC, acc, zf, cf before execution}; a
// monitor pops and compares on every retire pulse. Directed programs plus
// random programs, reset-mid-EXEC, a 4-bit-PC wrap instance and step mode.
module tb_acc_cpu_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst5_n = 1'b0;
    logic       step_en = 1'b0;
    logic       step = 1'b0;

    logic [7:0] pc;
    logic [7:0] acc;
    logic       halt, zf, cf, retire;

    logic [3:0] pc5;
    logic [7:0] acc5;
    logic       halt5, zf5, cf5, retire5;

    int total = 0;
    int bad = 0;
    int retire_cnt = 0;
    int halt_cyc = -1;

    logic [17:0] exp_q[$];
    logic [17:0] e;

    // Reference model state
    int m_imem [256];
    int m_dmem [16];
    int m_pc, m_acc, m_zf, m_cf, m_halt, m_count;

    always #5 clk = ~clk;

    acc_cpu_param dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef ACC_CPU_STEP_EN
        .step_en(step_en),
        .step   (step),
`endif
        .pc     (pc),
        .acc    (acc),
        .halt   (halt),
        .zf     (zf),
        .cf     (cf),
        .retire (retire)
    );

    acc_cpu_param #(.ADDR_W(4)) u5 (
        .clk    (clk),
        .rst_n  (rst5_n),
`ifdef ACC_CPU_STEP_EN
        .step_en(1'b0),
        .step   (1'b0),
`endif
        .pc     (pc5),
        .acc    (acc5),
        .halt   (halt5),
        .zf     (zf5),
        .cf     (cf5),
        .retire (retire5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every retire pulse consumes one predicted pre-execution state.
    always @(negedge clk) begin
        if (rst_n && retire) begin
            retire_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL retire_unexpected: got retire with empty queue, pc=%0h", pc);
            end else begin
                e = exp_q.pop_front();
                check("retire_state", {pc, acc, zf, cf}, e);
            end
        end
    end

    // Instruction-level interpreter of the ISA, run up to max_instr instructions.
    task automatic model_run(input int max_instr);
        int p, a, z, c, n, op, k, m;
        p = 0; a = 0; z = 0; c = 0; n = 0;
        m_halt = 0;
        while (n < max_instr && m_halt == 0) begin
            op = m_imem[p] / 16;
            k  = m_imem[p] % 16;
            p  = (p + 1) % 256;
            exp_q.push_back({p[7:0], a[7:0], z[0], c[0]});
            m = m_dmem[k];
            case (op)
                1:  a = m;
                2:  m_dmem[k] = a;
                3:  begin c = (a + m > 255) ? 1 : 0; a = (a + m) % 256; end
                4:  begin c = (a < m) ? 1 : 0; a = (a - m + 256) % 256; end
                5:  a = k;
                6:  a = a & m;
                7:  a = a | m;
                8:  a = a ^ m;
                9:  p = k;
                10: if (z != 0) p = k;
                11: if (c != 0) p = k;
                15: m_halt = 1;
                default: ;
            endcase
            if (op == 1 || (op >= 3 && op <= 8)) z = (a == 0) ? 1 : 0;
            n++;
        end
        m_pc = p; m_acc = a; m_zf = z; m_cf = c; m_count = n;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) m_imem[i] = 8'hF0;
        for (int i = 0; i < 16; i++) m_dmem[i] = 0;
    endtask

    task automatic start_prog(input bit load_dmem, input int max_instr);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) dut.imem[i] = 8'(m_imem[i]);
        if (load_dmem)
            for (int i = 0; i < 16; i++) dut.dmem[i] = 8'(m_dmem[i]);
        model_run(max_instr);
        retire_cnt = 0;
        halt_cyc = -1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_prog(input string tag, input int budget);
        bit done;
        done = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (halt && halt_cyc < 0) halt_cyc = cyc;
            if (exp_q.size() == 0 && (m_halt == 0 || halt)) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: %0d entries left, halt=%0b", tag, exp_q.size(), halt);
            exp_q.delete();
        end
        if (m_halt == 0) begin
            rst_n = 1'b0;
            check({tag, "_retires"}, retire_cnt, m_count);
        end else begin
            repeat (3) @(negedge clk);
            check({tag, "_retires"}, retire_cnt, m_count);
            check({tag, "_halt"}, halt, 1);
            check({tag, "_pc"}, pc, m_pc);
            check({tag, "_acc"}, acc, m_acc);
            check({tag, "_zf"}, zf, m_zf);
            check({tag, "_cf"}, cf, m_cf);
            for (int i = 0; i < 16; i++) check({tag, "_dmem"}, dut.dmem[i], m_dmem[i]);
        end
    endtask

    task automatic load_legacy();
        clear_model();
        m_imem[0] = 'h55; m_imem[1] = 'h31; m_imem[2] = 'h22; m_imem[3] = 'h13;
        m_imem[4] = 'h42; m_imem[5] = 'h24; m_imem[6] = 'hF0;
        m_dmem[1] = 3; m_dmem[3] = 10;
    endtask

    initial begin
        int n;
        int c0;
        bit ok;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_pc", pc, 0);
        check("reset_acc", acc, 0);
        check("reset_flags", {halt, zf, cf, retire}, 0);

        // Legacy program
        load_legacy();
        start_prog(1, 64);
        finish_prog("legacy", 60);
        check("legacy_dmem2", dut.dmem[2], 8'h08);
        check("legacy_dmem4", dut.dmem[4], 8'h02);
        check("legacy_pc7", pc, 8'h07);
        check("legacy_halt_by_14", (halt_cyc > 0 && halt_cyc <= 14), 1);

        // Carry and borrow
        clear_model();
        m_imem[0] = 'h5F; m_imem[1] = 'h30; m_imem[2] = 'h40; m_imem[3] = 'hF0;
        m_dmem[0] = 'hF2;
        start_prog(1, 64);
        finish_prog("carry", 60);
        check("borrow_acc", acc, 8'h0F);
        check("borrow_cf", cf, 1);

        // Countdown loop
        clear_model();
        m_imem[0] = 'h11; m_imem[1] = 'h40; m_imem[2] = 'h21;
        m_imem[3] = 'hA5; m_imem[4] = 'h91; m_imem[5] = 'hF0;
        m_dmem[0] = 1; m_dmem[1] = 3;
        start_prog(1, 64);
        finish_prog("loop", 100);
        check("loop_dmem1", dut.dmem[1], 0);
        check("loop_zf", zf, 1);
        check("loop_pc", pc, 6);

        // Reset in the middle of the fifth instruction's EXEC
        load_legacy();
        start_prog(1, 64);
        ok = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (retire_cnt >= 5) begin ok = 1; break; end
        end
        check("midreset_reached", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_pc", pc, 0);
        check("midreset_acc", acc, 0);
        check("midreset_flags", {halt, zf, cf}, 0);
        check("midreset_dmem1", dut.dmem[1], 3);
        check("midreset_dmem2", dut.dmem[2], 8);
        check("midreset_dmem3", dut.dmem[3], 10);
        load_legacy();
        m_dmem[2] = 8;
        start_prog(0, 64);
        finish_prog("rerun", 60);
        check("rerun_dmem4", dut.dmem[4], 2);

        // Random programs
        for (int r = 0; r < 6; r++) begin
            clear_model();
            for (int i = 0; i < 64; i++) m_imem[i] = $urandom_range(0, 255);
            for (int i = 0; i < 16; i++) m_dmem[i] = $urandom_range(0, 255);
            start_prog(1, 120);
            finish_prog("random", 300);
        end

        // 4-bit PC instance wraps 15 -> 0 over NOPs
        for (int i = 0; i < 16; i++) u5.imem[i] = 8'h00;
        @(negedge clk);
        rst5_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 20; cyc++) begin
            @(negedge clk);
            if (retire5) begin
                n++;
                check("wrap_pc", pc5, n % 16);
                check("wrap_halt", halt5, 0);
            end
        end
        check("wrap_count", n, 20);

`ifdef ACC_CPU_STEP_EN
        // Single-step mode
        step_en = 1'b1;
        load_legacy();
        start_prog(1, 64);
        repeat (10) @(negedge clk);
        check("step_idle_pc", pc, 0);
        check("step_idle_retire", retire_cnt, 0);
        for (int s = 0; s < 3; s++) begin
            c0 = retire_cnt;
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (5) @(negedge clk);
            check("step_one_retire", retire_cnt - c0, 1);
        end
        step_en = 1'b0;
        finish_prog("step_run", 60);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
